fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 169 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: funnels NUM_REQ beat streams into one FIFO write port in bursts.
// Latency: grant one cycle after the IDLE decision; fifo_wr_en/fifo_wr_data one cycle after ack.
// Backpressure: fifo_full, or fifo_afull with a write in flight, stalls the owner (beat count held, no timeout).
//
// Ports:
//   clk, rst          - single clock (FIFO write clock), asynchronous active-high reset
//   req, req_data     - per-requester beat valid and flattened data (requester i at [i*DATA_WIDTH +: DATA_WIDTH])
//   ack               - combinational, beat from requester i accepted this cycle
//   gnt, busy         - registered one-hot owner (zero when idle) and burst-in-progress flag
//   fifo_full/afull   - FIFO status; afull means at most one free entry
//   fifo_wr_en/data   - registered FIFO write port
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    input  logic                          fifo_afull,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic [NUM_REQ-1:0]      gnt_d;
    logic                    wr_en_d;
    logic [DATA_WIDTH-1:0]   wr_data_d;
    logic                    busy_d;

    logic                    accept;
    logic [IDX_W-1:0]        pick_idx;
    logic [IDX_W-1:0]        next_ptr;
    logic [DATA_WIDTH-1:0]   req_slice [NUM_REQ];

    // Unflatten the requester data bus.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign req_slice[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // First set request bit at or above ptr, wrapping from NUM_REQ-1 back to 0.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] cand_idx;
        logic             found;
        int               cand;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!found && r[cand_idx]) begin
                found = 1'b1;
                sel   = cand_idx;
            end
        end
        return sel;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign pick_idx = rr_pick(req, rr_ptr_q);
    assign next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);

    // A write registered last cycle plus afull means the FIFO may have no room
    // left for this beat, so the afull flag only blocks when a write is in flight.
    // rst gating keeps ack low for the whole reset window, not just after the flop clears.
    assign accept = (state_q == BURST) && !rst && req[owner_q] && !fifo_full &&
                    !(fifo_wr_en && fifo_afull);

    always_comb begin
        ack = '0;
        if (accept) begin
            ack[owner_q] = 1'b1;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        wr_en_d    = 1'b0;
        wr_data_d  = fifo_wr_data;

        case (state_q)
            IDLE: begin
                // No beat is taken in IDLE; the owner's first beat can be acked
                // in the same cycle gnt rises.
                if (|req) begin
                    state_d    = BURST;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (accept) begin
                    wr_en_d    = 1'b1;
                    wr_data_d  = req_slice[owner_q];
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
                // Release on the last beat of the tenure, or as soon as the owner
                // stops requesting (a stalled owner with req high keeps the grant).
                if ((accept && (beat_cnt_q == LAST_BEAT)) || !req[owner_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        gnt_d  = (state_d == BURST) ? onehot(owner_d) : '0;
        busy_d = (state_d == BURST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            beat_cnt_q   <= '0;
            gnt          <= '0;
            busy         <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            gnt          <= gnt_d;
            busy         <= busy_d;
            fifo_wr_en   <= wr_en_d;
            fifo_wr_data <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: single requester, fairness, full/afull stalls,
// early release and reset mid-burst, with hand-computed expectations.
// Inputs change 2 time units after a rising edge; outputs are sampled 1 unit later.
module tb_fifo_wr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [15:0] req_data;
    logic [3:0] ack;
    logic [3:0] gnt;
    logic       fifo_full;
    logic       fifo_afull;
    logic       fifo_wr_en;
    logic [3:0] fifo_wr_data;
    logic       busy;

    logic [3:0] dat [4];
    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (4),
        .MAX_BURST  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .gnt          (gnt),
        .fifo_full    (fifo_full),
        .fifo_afull   (fifo_afull),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req        = 4'b1111;
        fifo_full  = 1'b0;
        fifo_afull = 1'b0;
        for (int i = 0; i < 4; i++) dat[i] = 4'h0;

        // ---------------- reset state ----------------
        #3;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_en", fifo_wr_en, 1'b0);
        chk("rst_wr_data", fifo_wr_data, 4'h0);
        chk("rst_ack", ack, 4'b0000);
        cyc();
        settle();
        chk("rst_ack_clocked", ack, 4'b0000);
        req = 4'b0000;
        cyc();
        rst = 1'b0;
        cyc();

        // ---------------- single requester ----------------
        req    = 4'b0100;
        dat[2] = 4'hA;
        settle();
        chk("single_idle_ack", ack, 4'b0000);
        cyc();
        settle();
        chk("single_gnt", gnt, 4'b0100);
        chk("single_busy", busy, 1'b1);
        chk("single_ack0", ack, 4'b0100);
        for (int k = 0; k < 4; k++) begin
            cyc();
            settle();
            chk("single_wr_en", fifo_wr_en, 1'b1);
            chk("single_wr_data", fifo_wr_data, 32'(4'hA + k));
            if (k < 3) begin
                dat[2] = 4'(4'hA + k + 1);
                settle();
                chk("single_ack", ack, 4'b0100);
            end
        end
        chk("single_idle_gnt", gnt, 4'b0000);
        chk("single_idle_busy", busy, 1'b0);
        chk("single_idle_ack", ack, 4'b0000);
        cyc();
        settle();
        chk("single_regrant", gnt, 4'b0100);
        chk("single_regrant_wr_en", fifo_wr_en, 1'b0);
        req = 4'b0000;
        settle();
        chk("single_drop_ack", ack, 4'b0000);
        cyc();
        settle();
        chk("single_drop_gnt", gnt, 4'b0000);

        // ---------------- fairness, all requesting ----------------
        do_reset();
        for (int i = 0; i < 4; i++) dat[i] = 4'(4'h1 + i);
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            cyc();
            settle();
            chk("fair_gnt", gnt, 32'(4'b0001 << (t % 4)));
            for (int b = 0; b < 4; b++) begin
                chk("fair_ack", ack, 32'(4'b0001 << (t % 4)));
                cyc();
                settle();
                chk("fair_wr_en", fifo_wr_en, 1'b1);
                chk("fair_wr_data", fifo_wr_data, 32'(1 + (t % 4)));
            end
            chk("fair_gap_gnt", gnt, 4'b0000);
            chk("fair_gap_ack", ack, 4'b0000);
        end
        req = 4'b0000;

        // ---------------- full backpressure ----------------
        do_reset();
        req    = 4'b0010;
        dat[1] = 4'h5;
        cyc();
        settle();
        chk("bp_gnt", gnt, 4'b0010);
        chk("bp_ack1", ack, 4'b0010);
        cyc();
        settle();
        chk("bp_wr1", fifo_wr_data, 4'h5);
        dat[1] = 4'h6;
        settle();
        chk("bp_ack2", ack, 4'b0010);
        cyc();
        settle();
        chk("bp_wr2", fifo_wr_data, 4'h6);
        dat[1]    = 4'h7;
        fifo_full = 1'b1;
        settle();
        chk("bp_full_ack_a", ack, 4'b0000);
        cyc();
        settle();
        chk("bp_full_wr_en_a", fifo_wr_en, 1'b0);
        chk("bp_full_hold_data", fifo_wr_data, 4'h6);
        chk("bp_full_ack_b", ack, 4'b0000);
        chk("bp_full_gnt", gnt, 4'b0010);
        cyc();
        settle();
        chk("bp_full_wr_en_b", fifo_wr_en, 1'b0);
        chk("bp_full_ack_c", ack, 4'b0000);
        cyc();
        settle();
        chk("bp_full_wr_en_c", fifo_wr_en, 1'b0);
        fifo_full = 1'b0;
        settle();
        chk("bp_ack3", ack, 4'b0010);
        cyc();
        settle();
        chk("bp_wr3_en", fifo_wr_en, 1'b1);
        chk("bp_wr3", fifo_wr_data, 4'h7);
        dat[1] = 4'h8;
        settle();
        chk("bp_ack4", ack, 4'b0010);
        cyc();
        settle();
        chk("bp_wr4", fifo_wr_data, 4'h8);
        chk("bp_end_gnt", gnt, 4'b0000);
        req = 4'b0000;
        cyc();
        settle();
        chk("bp_no_dup", fifo_wr_en, 1'b0);

        // ---------------- almost-full (rr_ptr now 2) ----------------
        req    = 4'b0001;
        dat[0] = 4'h1;
        cyc();
        settle();
        chk("af_gnt", gnt, 4'b0001);
        fifo_afull = 1'b1;
        settle();
        chk("af_no_write_inflight_ack", ack, 4'b0001);
        cyc();
        settle();
        chk("af_wr1", fifo_wr_data, 4'h1);
        dat[0] = 4'h2;
        settle();
        chk("af_stall_ack", ack, 4'b0000);
        cyc();
        settle();
        chk("af_stall_wr_en", fifo_wr_en, 1'b0);
        fifo_afull = 1'b0;
        settle();
        chk("af_resume_ack", ack, 4'b0001);
        cyc();
        settle();
        chk("af_wr2", fifo_wr_data, 4'h2);
        req = 4'b0000;
        settle();
        chk("af_drop_ack", ack, 4'b0000);
        cyc();
        settle();
        chk("af_drop_gnt", gnt, 4'b0000);

        // ---------------- early release (rr_ptr now 1) ----------------
        req    = 4'b0010;
        dat[1] = 4'h3;
        cyc();
        settle();
        chk("er_gnt", gnt, 4'b0010);
        cyc();
        dat[1] = 4'h4;
        settle();
        chk("er_ack2", ack, 4'b0010);
        cyc();
        req = 4'b0001;
        settle();
        chk("er_wr2", fifo_wr_data, 4'h4);
        chk("er_drop_ack", ack, 4'b0000);
        cyc();
        settle();
        chk("er_idle_gnt", gnt, 4'b0000);
        req = 4'b0011;
        cyc();
        settle();
        chk("er_regrant_0", gnt, 4'b0001);
        req = 4'b0000;
        cyc();

        // ---------------- reset mid-burst (rr_ptr now 1) ----------------
        req    = 4'b0100;
        dat[2] = 4'h9;
        cyc();
        settle();
        chk("rb_gnt", gnt, 4'b0100);
        cyc();
        settle();
        chk("rb_ack2", ack, 4'b0100);
        cyc();
        settle();
        chk("rb_wr_en_before", fifo_wr_en, 1'b1);
        rst = 1'b1;
        settle();
        chk("rb_gnt_now", gnt, 4'b0000);
        chk("rb_busy_now", busy, 1'b0);
        chk("rb_wr_en_now", fifo_wr_en, 1'b0);
        chk("rb_ack_now", ack, 4'b0000);
        cyc();
        settle();
        chk("rb_wr_en_held", fifo_wr_en, 1'b0);
        rst = 1'b0;
        req = 4'b1000;
        cyc();
        settle();
        chk("rb_post_gnt", gnt, 4'b1000);
        req = 4'b0000;
        cyc();
        cyc();
        do_reset();
        req = 4'b1010;
        cyc();
        settle();
        chk("rb_search_from_0", gnt, 4'b0010);
        req = 4'b0000;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
